uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver (start/data/stop), LSB first.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 I_rx_en,
  input  logic                 I_baudrate_rx_clk,
  input  logic                 I_rx_serial,
  output logic [DATA_BITS-1:0] O_rx_data,
  output logic                 O_rx_valid,
  output logic                 O_rx_frame_err,
  output logic                 O_rx_busy
);

  localparam int                  c_TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(OVERSAMPLE/2 - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
  localparam logic [2:0]          c_BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]          c_BIT_ONE   = 3'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic                 r_sync_meta;
  logic                 r_sync_line;
  logic                 r_line_prev;
  state_t               r_state;
  logic [c_TICK_W-1:0]  r_tick;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;

  state_t               w_state_nx;
  logic [c_TICK_W-1:0]  w_tick_nx;
  logic [2:0]           w_bit_nx;
  logic [DATA_BITS-1:0] w_shift_nx;
  logic [DATA_BITS-1:0] w_data_nx;
  logic                 w_valid_nx;
  logic                 w_frame_err_nx;
  logic                 w_fall;

  // Edge detect on the synchronized line: a line held low (break) never
  // re-triggers until it has been seen high again.
  assign w_fall = r_line_prev & ~r_sync_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_meta <= 1'b1;
      r_sync_line <= 1'b1;
      r_line_prev <= 1'b1;
    end else begin
      r_sync_meta <= I_rx_serial;
      r_sync_line <= r_sync_meta;
      r_line_prev <= r_sync_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_tick      <= w_tick_nx;
      r_bit       <= w_bit_nx;
      r_shift     <= w_shift_nx;
      r_data      <= w_data_nx;
      r_valid     <= w_valid_nx;
      r_frame_err <= w_frame_err_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_tick_nx      = r_tick;
    w_bit_nx       = r_bit;
    w_shift_nx     = r_shift;
    w_data_nx      = r_data;
    w_valid_nx     = 1'b0;
    w_frame_err_nx = 1'b0;

    if (!I_rx_en) begin
      w_state_nx = S_IDLE;
      w_tick_nx  = '0;
      w_bit_nx   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            w_state_nx = S_START;
            w_tick_nx  = '0;
            w_bit_nx   = '0;
          end
        end

        S_START: begin
          if (I_baudrate_rx_clk) begin
            if (r_tick == c_TICK_MID) begin
              // Mid start bit: a high line means the edge was a glitch.
              w_state_nx = r_sync_line ? S_IDLE : S_DATA;
              w_tick_nx  = '0;
              w_bit_nx   = '0;
            end else begin
              w_tick_nx = r_tick + c_TICK_ONE;
            end
          end
        end

        S_DATA: begin
          if (I_baudrate_rx_clk) begin
            if (r_tick == c_TICK_LAST) begin
              w_shift_nx = {r_sync_line, r_shift[DATA_BITS-1:1]};
              w_tick_nx  = '0;
              w_bit_nx   = r_bit + c_BIT_ONE;
              if (r_bit == c_BIT_LAST) begin
                w_state_nx = S_STOP;
                w_bit_nx   = '0;
              end
            end else begin
              w_tick_nx = r_tick + c_TICK_ONE;
            end
          end
        end

        S_STOP: begin
          if (I_baudrate_rx_clk) begin
            if (r_tick == c_TICK_LAST) begin
              if (r_sync_line) begin
                w_data_nx  = r_shift;
                w_valid_nx = 1'b1;
              end else begin
                w_frame_err_nx = 1'b1;
              end
              w_state_nx = S_IDLE;
              w_tick_nx  = '0;
            end else begin
              w_tick_nx = r_tick + c_TICK_ONE;
            end
          end
        end

        default: begin
          w_state_nx = S_IDLE;
          w_tick_nx  = '0;
          w_bit_nx   = '0;
        end
      endcase
    end
  end

  assign O_rx_data      = r_data;
  assign O_rx_valid     = r_valid;
  assign O_rx_frame_err = r_frame_err;
  assign O_rx_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx at default params.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int c_DB       = 8;
  localparam int c_OS       = 16;
  localparam int c_TICK_DIV = 4;
  localparam int c_LATENCY  = c_OS/2 + (c_DB+1)*c_OS;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en = 1'b0;
  logic       tick  = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic       rx_busy;

  uart_rx #(
    .DATA_BITS (c_DB),
    .OVERSAMPLE(c_OS)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .I_rx_en          (rx_en),
    .I_baudrate_rx_clk(tick),
    .I_rx_serial      (rx),
    .O_rx_data        (rx_data),
    .O_rx_valid       (rx_valid),
    .O_rx_frame_err   (rx_ferr),
    .O_rx_busy        (rx_busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         tick_cnt = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         both_high = 0;
  int         last_valid_tick = 0;
  int         start_tick = 0;
  logic [7:0] last_data = 8'h00;

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      div  = (div + 1) % c_TICK_DIV;
      tick = (div == 0);
    end
  end

  always @(posedge clk) begin
    if (tick) tick_cnt <= tick_cnt + 1;
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid         <= n_valid + 1;
      last_data       <= rx_data;
      last_valid_tick <= tick_cnt;
    end
    if (rx_ferr) n_ferr <= n_ferr + 1;
    if (rx_valid && rx_ferr) both_high <= both_high + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (!tick);
  endtask

  task automatic send_bit(input logic b, input int n);
    @(negedge clk);
    rx = b;
    repeat (n) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
    if (gap > 0) send_bit(1'b1, gap);
    @(negedge clk);
    rx         = 1'b0;
    start_tick = tick_cnt;
    repeat (c_OS) wait_tick();
    for (int i = 0; i < c_DB; i++) send_bit(d[i], c_OS);
    send_bit(stop, c_OS);
  endtask

  // Start bit, nbits full data bits, then half of the next data bit.
  task automatic send_partial(input logic [7:0] d, input int nbits);
    send_bit(1'b1, 4);
    send_bit(1'b0, c_OS);
    for (int i = 0; i < nbits; i++) send_bit(d[i], c_OS);
    send_bit(d[nbits], c_OS/2);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         gap;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[6];

  initial begin : test
    int v0;
    int f0;

    vecs[0] = '{8'hA5, 1'b1,  4, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1,  4, 1, 0, 8'h3C};
    vecs[2] = '{8'h81, 1'b0,  4, 0, 1, 8'h3C};
    vecs[3] = '{8'h00, 1'b1, 20, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1,  0, 1, 0, 8'hFF};
    vecs[5] = '{8'h96, 1'b1,  6, 1, 0, 8'h96};

    rx_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset data",  int'(rx_data),  0);
    check("reset valid", int'(rx_valid), 0);
    check("reset ferr",  int'(rx_ferr),  0);
    check("reset busy",  int'(rx_busy),  0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      v0 = n_valid;
      f0 = n_ferr;
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].gap);
      check($sformatf("vec%0d valid count", i), n_valid - v0, vecs[i].exp_v);
      check($sformatf("vec%0d ferr count", i),  n_ferr - f0,  vecs[i].exp_f);
      check($sformatf("vec%0d data", i),        int'(rx_data), int'(vecs[i].exp_d));
      if (vecs[i].exp_v != 0)
        check($sformatf("vec%0d latency", i), last_valid_tick - start_tick, c_LATENCY);
    end

    // Glitch: low for 4 ticks, rejected at the 8th tick.
    v0 = n_valid;
    f0 = n_ferr;
    send_bit(1'b1, 4);
    send_bit(1'b0, 4);
    send_bit(1'b1, 3);
    @(negedge clk);
    check("glitch busy tick7", int'(rx_busy), 1);
    wait_tick();
    @(negedge clk);
    check("glitch idle tick8", int'(rx_busy), 0);
    repeat (40) wait_tick();
    @(negedge clk);
    check("glitch busy after", int'(rx_busy), 0);
    check("glitch valid", n_valid - v0, 0);
    check("glitch ferr",  n_ferr - f0,  0);

    // Break: bad stop bit, line stays low afterwards.
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h12, 1'b0, 4);
    repeat (48) wait_tick();
    @(negedge clk);
    check("break busy",  int'(rx_busy), 0);
    check("break ferr",  n_ferr - f0,  1);
    check("break valid", n_valid - v0, 0);
    check("break data",  int'(rx_data), 8'h96);
    v0 = n_valid;
    send_frame(8'hC3, 1'b1, 4);
    check("after break valid", n_valid - v0, 1);
    check("after break data",  int'(last_data), 8'hC3);

    // Reset during data bit 3.
    send_partial(8'hF0, 3);
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    check("midreset data",  int'(rx_data),  0);
    check("midreset valid", int'(rx_valid), 0);
    check("midreset ferr",  int'(rx_ferr),  0);
    check("midreset busy",  int'(rx_busy),  0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h5A, 1'b1, 8);
    check("post reset valid", n_valid - v0, 1);
    check("post reset ferr",  n_ferr - f0,  0);
    check("post reset data",  int'(rx_data), 8'h5A);

    // Enable dropped during data bit 5.
    v0 = n_valid;
    f0 = n_ferr;
    send_partial(8'hE7, 5);
    @(negedge clk);
    rx_en = 1'b0;
    repeat (4) wait_tick();
    @(negedge clk);
    check("disabled busy", int'(rx_busy), 0);
    check("disabled data", int'(rx_data), 8'h5A);
    rx = 1'b1;
    repeat (4) wait_tick();
    @(negedge clk);
    rx_en = 1'b1;
    send_frame(8'h66, 1'b1, 8);
    check("reenable valid", n_valid - v0, 1);
    check("reenable ferr",  n_ferr - f0,  0);
    check("reenable data",  int'(rx_data), 8'h66);

    check("valid and ferr together", both_high, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
